// File: rtl/eeprom_req_arb.sv
// Round-robin sequencer for two byte-command requesters (A=host, B=boot loader) into one EEPROM engine.
// Idle read with immediate ACK: REQ -> DONE in 3 + ack delay cycles; define EEPROM_ARB_WP_EN to reject writes at/above WP_BASE.
module eeprom_req_arb #(
  parameter int          TIMEOUT_CYC = 100000,
  parameter int          TWR_CYC     = 500000,
  parameter int          CNT_W       = 20,
  parameter logic [10:0] WP_BASE     = 11'h700
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        A_REQ,
  input  logic        A_WE,
  input  logic [10:0] A_ADDR,
  input  logic [7:0]  A_WDATA,
  output logic        A_DONE,
  output logic        A_ERR,
  output logic [7:0]  A_RDATA,
  input  logic        B_REQ,
  input  logic        B_WE,
  input  logic [10:0] B_ADDR,
  input  logic [7:0]  B_WDATA,
  output logic        B_DONE,
  output logic        B_ERR,
  output logic [7:0]  B_RDATA,
  output logic        EE_WR,
  output logic        EE_RD,
  output logic [10:0] EE_ADDR,
  output logic [7:0]  EE_DATA_O,
  output logic        EE_DATA_OE,
  input  logic [7:0]  EE_DATA_I,
  input  logic        EE_ACK,
  output logic        BUSY
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, TWR, FIN} state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] TWR_LAST = CNT_W'(TWR_CYC - 1);

`ifdef EEPROM_ARB_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  state_t           state, state_nxt;
  logic             last_b, gnt_b, we_q, err_q, ack_q;
  logic [CNT_W-1:0] cnt;
  logic             pick_b, sel_we, wp_hit, ack_rise;
  logic [10:0]      sel_addr;
  logic [7:0]       sel_wdata;
  logic             grant, cnt_clr, cnt_inc, set_err, capture;

  // B wins when it is alone, or on a tie when A was granted last.
  always_comb begin
    pick_b    = B_REQ & (~A_REQ | ~last_b);
    sel_we    = pick_b ? B_WE    : A_WE;
    sel_addr  = pick_b ? B_ADDR  : A_ADDR;
    sel_wdata = pick_b ? B_WDATA : A_WDATA;
    wp_hit    = WP_EN & sel_we & (sel_addr >= WP_BASE);
    ack_rise  = EE_ACK & ~ack_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    set_err   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (A_REQ | B_REQ) begin
          grant     = 1'b1;
          state_nxt = wp_hit ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        cnt_clr   = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        // ACK is checked first so an ACK on the timeout cycle still succeeds.
        if (ack_rise) begin
          capture   = ~we_q;
          cnt_clr   = 1'b1;
          state_nxt = we_q ? TWR : FIN;
        end else if (cnt >= TO_LAST) begin
          set_err   = 1'b1;
          state_nxt = FIN;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      TWR: begin
        if (cnt >= TWR_LAST) state_nxt = FIN;
        else                 cnt_inc   = 1'b1;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    EE_WR      = (state == ISSUE) & we_q;
    EE_RD      = (state == ISSUE) & ~we_q;
    EE_DATA_OE = we_q & ((state == ISSUE) | (state == WAIT_ACK));
    A_DONE     = (state == FIN) & ~gnt_b;
    B_DONE     = (state == FIN) & gnt_b;
    A_ERR      = A_DONE & err_q;
    B_ERR      = B_DONE & err_q;
    BUSY       = (state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      last_b    <= 1'b1;
      gnt_b     <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
      cnt       <= '0;
      EE_ADDR   <= '0;
      EE_DATA_O <= '0;
      A_RDATA   <= '0;
      B_RDATA   <= '0;
    end else begin
      ack_q <= EE_ACK;
      if (grant) begin
        gnt_b     <= pick_b;
        we_q      <= sel_we;
        EE_ADDR   <= sel_addr;
        EE_DATA_O <= sel_wdata;
        err_q     <= wp_hit;
      end
      if (set_err) err_q <= 1'b1;
      // Saturating counter shared by the ACK timeout and the write-cycle wait.
      if (cnt_clr)                      cnt <= '0;
      else if (cnt_inc && (cnt != '1))  cnt <= cnt + 1'b1;
      if (capture) begin
        if (gnt_b) B_RDATA <= EE_DATA_I;
        else       A_RDATA <= EE_DATA_I;
      end
      if (state == FIN) last_b <= gnt_b;
    end
  end

endmodule
